// File: rtl/sayeh_mem_wait_ctrl.sv
// Memory stage behind the SAYEH controller: word RAM with programmable wait states,
// posted writes through a one-entry pending slot, and a one-cycle read-ready strobe.
module sayeh_mem_wait_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              ExternalReset,
  input  logic              ReadMem,
  input  logic              WriteMem,
  input  logic [15:0]       Address,
  input  logic [15:0]       DataIn,
  output logic [15:0]       DataOut,
  output logic              memDataReady,
  output logic              Busy,
  output logic              WriteOverrun,
  input  logic              InitWe,
  input  logic [ADDR_W-1:0] InitAddr,
  input  logic [15:0]       InitData
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_WAIT = 3'd1,
    S_RD_DONE = 3'd2,
    S_WR_WAIT = 3'd3,
    S_WR_DONE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         data_q, data_d;
  logic                pend_vld_q, pend_vld_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic [15:0]         pend_data_q, pend_data_d;
  logic [15:0]         dout_q, dout_d;
  logic                rdy_q, rdy_d;
  logic                busy_q, busy_d;
  logic                ovr_q, ovr_d;

  logic [15:0]         mem_q [DEPTH];
  logic                mem_we_s;
  logic [ADDR_W-1:0]   mem_waddr_s;
  logic [15:0]         mem_wdata_s;
  logic [ADDR_W-1:0]   req_addr_s;
  logic                unused_addr_hi_s;

  // Addresses wrap modulo the RAM depth, so the upper address bits are ignored.
  assign req_addr_s       = Address[ADDR_W-1:0];
  assign unused_addr_hi_s = ^Address[15:ADDR_W];

  // Next-state, datapath and pending-slot logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    dout_d      = dout_q;
    rdy_d       = 1'b0;
    ovr_d       = ovr_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = addr_q;
    mem_wdata_s = data_q;

    case (state_q)
      S_IDLE: begin
        if (pend_vld_q) begin
          // Draining the slot first keeps a read of the same address coherent.
          addr_d  = pend_addr_q;
          data_d  = pend_data_q;
          cnt_d   = WAIT_CNT;
          state_d = S_WR_WAIT;
          if (WriteMem) begin
            pend_vld_d  = 1'b1;
            pend_addr_d = req_addr_s;
            pend_data_d = DataIn;
          end else begin
            pend_vld_d  = 1'b0;
          end
        end else if (WriteMem) begin
          addr_d  = req_addr_s;
          data_d  = DataIn;
          cnt_d   = WAIT_CNT;
          state_d = S_WR_WAIT;
        end else if (ReadMem) begin
          addr_d  = req_addr_s;
          cnt_d   = WAIT_CNT;
          state_d = S_RD_WAIT;
        end else if (InitWe) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = InitAddr;
          mem_wdata_s = InitData;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          dout_d  = mem_q[addr_q];
          rdy_d   = 1'b1;
          state_d = S_RD_DONE;
        end
      end
      S_RD_DONE: begin
        state_d = S_IDLE;
      end
      S_WR_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_WR_DONE;
        end
      end
      S_WR_DONE: begin
        mem_we_s = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if ((state_q != S_IDLE) && WriteMem) begin
      if (!pend_vld_q) begin
        pend_vld_d  = 1'b1;
        pend_addr_d = req_addr_s;
        pend_data_d = DataIn;
      end else begin
        ovr_d = 1'b1;
      end
    end else begin
      ovr_d = ovr_d;
    end

    busy_d = (state_d != S_IDLE) | pend_vld_d;
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge ExternalReset) begin
    if (!ExternalReset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      data_q      <= 16'd0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= 16'd0;
      dout_q      <= 16'd0;
      rdy_q       <= 1'b0;
      busy_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      dout_q      <= dout_d;
      rdy_q       <= rdy_d;
      busy_q      <= busy_d;
      ovr_q       <= ovr_d;
    end
  end

  // RAM array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign DataOut      = dout_q;
  assign memDataReady = rdy_q;
  assign Busy         = busy_q;
  assign WriteOverrun = ovr_q;

endmodule
